// File: rtl/spi_slave_burst.sv
// SPI slave front end: 2-bit command, address, then a single word or an
// auto-incrementing burst, driving a synchronous single-port RAM directly.
module spi_slave_burst #(
  parameter int MEM_DEPTH = 256,
  parameter int DATA_W    = 8,
  localparam int ADDR_W   = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              frame_err
);

  localparam int MAX_BITS = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);
  localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
  // Next-word fetch is launched so rd_en lands in the second-to-last bit cycle.
  localparam logic [CNT_W-1:0]  PREFETCH  = CNT_W'(DATA_W - 3);
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = ADDR_W'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WR_DATA, RD_WAIT, RD_DATA, DONE} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                burst_reg, burst_next;
  logic                is_read_reg, is_read_next;
  logic [ADDR_W-1:0]   addr_shift_reg, addr_shift_next;
  logic [DATA_W-1:0]   rx_shift_reg, rx_shift_next;
  logic [DATA_W-1:0]   tx_shift_reg, tx_shift_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]   mem_wdata_reg, mem_wdata_next;
  logic                wr_en_reg, wr_en_next;
  logic                rd_en_reg, rd_en_next;
  logic                miso_reg, miso_next;
  logic                busy_reg, busy_next;
  logic                err_reg, err_next;

  logic [ADDR_W-1:0]   addr_full;
  logic [DATA_W-1:0]   wr_word;

  assign addr_full = ADDR_W'({addr_shift_reg, MOSI});
  assign wr_word   = DATA_W'({rx_shift_reg, MOSI});

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_MAX) ? '0 : a + ADDR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      burst_reg      <= 1'b0;
      is_read_reg    <= 1'b0;
      addr_shift_reg <= '0;
      rx_shift_reg   <= '0;
      tx_shift_reg   <= '0;
      addr_reg       <= '0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      wr_en_reg      <= 1'b0;
      rd_en_reg      <= 1'b0;
      miso_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      burst_reg      <= burst_next;
      is_read_reg    <= is_read_next;
      addr_shift_reg <= addr_shift_next;
      rx_shift_reg   <= rx_shift_next;
      tx_shift_reg   <= tx_shift_next;
      addr_reg       <= addr_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      wr_en_reg      <= wr_en_next;
      rd_en_reg      <= rd_en_next;
      miso_reg       <= miso_next;
      busy_reg       <= busy_next;
      err_reg        <= err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    burst_next      = burst_reg;
    is_read_next    = is_read_reg;
    addr_shift_next = addr_shift_reg;
    rx_shift_next   = rx_shift_reg;
    tx_shift_next   = tx_shift_reg;
    addr_next       = addr_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    wr_en_next      = 1'b0;
    rd_en_next      = 1'b0;
    err_next        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!SS_n) begin
          burst_next = MOSI;
          cnt_next   = '0;
          state_next = CMD;
        end
      end
      CMD: begin
        if (SS_n) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          is_read_next = MOSI;
          cnt_next     = '0;
          state_next   = ADDR;
        end
      end
      ADDR: begin
        if (SS_n) begin
          err_next   = 1'b1;
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          addr_shift_next = addr_full;
          if (cnt_reg == ADDR_LAST) begin
            cnt_next = '0;
            if ({1'b0, addr_full} >= DEPTH_LIM) begin
              err_next   = 1'b1;
              state_next = DONE;
            end else if (is_read_reg) begin
              mem_addr_next = addr_full;
              rd_en_next    = 1'b1;
              addr_next     = addr_inc(addr_full);
              state_next    = RD_WAIT;
            end else begin
              addr_next  = addr_full;
              state_next = WR_DATA;
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      WR_DATA: begin
        rx_shift_next = wr_word;
        // A word completed on the same edge SS_n rises is still written.
        if (cnt_reg == DATA_LAST) begin
          wr_en_next     = 1'b1;
          mem_addr_next  = addr_reg;
          mem_wdata_next = wr_word;
          addr_next      = addr_inc(addr_reg);
          cnt_next       = '0;
          state_next     = SS_n ? IDLE : (burst_reg ? WR_DATA : DONE);
        end else if (SS_n) begin
          err_next   = (cnt_reg != '0);
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      RD_WAIT: begin
        if (SS_n) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else if (cnt_reg == CNT_W'(1)) begin
          tx_shift_next = mem_rdata;
          cnt_next      = '0;
          state_next    = RD_DATA;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      RD_DATA: begin
        if (SS_n) begin
          err_next   = (cnt_reg != '0);
          cnt_next   = '0;
          state_next = IDLE;
        end else if (cnt_reg == DATA_LAST) begin
          cnt_next = '0;
          if (burst_reg) tx_shift_next = mem_rdata;
          else           state_next    = DONE;
        end else begin
          tx_shift_next = tx_shift_reg << 1;
          cnt_next      = cnt_reg + CNT_W'(1);
          if (burst_reg && cnt_reg == PREFETCH) begin
            rd_en_next    = 1'b1;
            mem_addr_next = addr_reg;
            addr_next     = addr_inc(addr_reg);
          end
        end
      end
      DONE: begin
        if (SS_n) begin
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    miso_next = (state_next == RD_DATA) ? tx_shift_next[DATA_W-1] : 1'b0;
    busy_next = (state_next != IDLE);
  end

  assign MISO      = miso_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_wr_en = wr_en_reg;
  assign mem_rd_en = rd_en_reg;
  assign busy      = busy_reg;
  assign frame_err = err_reg;

endmodule

// File: tb/tb_spi_slave_burst.sv
// Directed bench for spi_slave_burst: a 256-word instance backed by a RAM
// model, plus a 200-word instance for range-check and non-power-of-two wrap.
module tb_spi_slave_burst;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       ss_n_a, mosi_a, miso_a, wr_a, rd_a, busy_a, err_a;
  logic [7:0] addr_a, wdata_a, rdata_a;
  logic       ss_n_b, mosi_b, miso_b, wr_b, rd_b, busy_b, err_b;
  logic [7:0] addr_b, wdata_b;
  logic [7:0] rdata_b = 8'h00;

  spi_slave_burst #(.MEM_DEPTH(256), .DATA_W(8)) dut_a (
    .clk(clk), .rst(rst), .SS_n(ss_n_a), .MOSI(mosi_a), .MISO(miso_a),
    .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_wr_en(wr_a), .mem_rd_en(rd_a),
    .mem_rdata(rdata_a), .busy(busy_a), .frame_err(err_a)
  );

  spi_slave_burst #(.MEM_DEPTH(200), .DATA_W(8)) dut_b (
    .clk(clk), .rst(rst), .SS_n(ss_n_b), .MOSI(mosi_b), .MISO(miso_b),
    .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_wr_en(wr_b), .mem_rd_en(rd_b),
    .mem_rdata(rdata_b), .busy(busy_b), .frame_err(err_b)
  );

  // Synchronous RAM behind instance A: read data valid the cycle after rd_en.
  logic [7:0] ram [0:255];
  always @(posedge clk) begin
    if (wr_a) ram[addr_a] <= wdata_a;
    if (rd_a) rdata_a <= ram[addr_a];
  end

  int wr_cnt_a = 0, rd_cnt_a = 0, wr_cnt_b = 0, rd_cnt_b = 0;
  always @(negedge clk) begin
    if (wr_a) wr_cnt_a++;
    if (rd_a) rd_cnt_a++;
    if (wr_b) wr_cnt_b++;
    if (rd_b) rd_cnt_b++;
  end

  int tests = 0;
  int fails = 0;
  logic sel_b = 1'b0;
  logic [7:0] wdat [3];
  logic [7:0] wexp [3];
  logic [7:0] rexp [3];
  logic [7:0] raexp [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end else begin
      $display("[TB] ok %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ss, input logic b);
    if (sel_b) begin ss_n_b = ss; mosi_b = b; end
    else       begin ss_n_a = ss; mosi_a = b; end
  endtask

  task automatic send_bit(input logic b);
    drive(1'b0, b);
    tick();
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic ss_high();
    drive(1'b1, 1'b0);
    tick();
  endtask

  // Write frame on instance A using wdat/wexp; trailing junk after a single word.
  task automatic write_frame(input string tag, input logic burst, input logic [7:0] addr, input int n);
    int w0;
    w0 = wr_cnt_a;
    send_bit(burst);
    send_bit(1'b0);
    send_bits(addr, 8);
    for (int k = 0; k < n; k++) begin
      send_bits(wdat[k], 8);
      check($sformatf("%s w%0d wr_en", tag, k), wr_a, 1);
      check($sformatf("%s w%0d addr", tag, k), addr_a, wexp[k]);
      check($sformatf("%s w%0d wdata", tag, k), wdata_a, wdat[k]);
    end
    if (!burst) begin
      send_bits(16'hC3, 8);
      check({tag, " busy in done"}, busy_a, 1);
    end
    ss_high();
    check({tag, " busy end"}, busy_a, 0);
    check({tag, " no err"}, err_a, 0);
    check({tag, " wr count"}, wr_cnt_a - w0, n);
  endtask

  // Read frame on instance A using rexp (data) and raexp (rd_en addresses).
  task automatic read_frame(input string tag, input logic burst, input logic [7:0] addr, input int n, input int rds);
    int r0;
    r0 = rd_cnt_a;
    send_bit(burst);
    send_bit(1'b1);
    send_bits(addr, 8);
    check({tag, " rd_en"}, rd_a, 1);
    check({tag, " rd addr"}, addr_a, addr);
    check({tag, " miso idle"}, miso_a, 0);
    send_bit(1'b0);
    check({tag, " rd_en one cycle"}, rd_a, 0);
    send_bit(1'b0);
    for (int i = 0; i < n * 8; i++) begin
      check($sformatf("%s bit%0d", tag, i), miso_a, rexp[i / 8][7 - (i % 8)]);
      if (burst) begin
        check($sformatf("%s rd_en@%0d", tag, i), rd_a, ((i % 8) == 6) ? 1 : 0);
        if ((i % 8) == 6 && (i / 8) < 2)
          check($sformatf("%s prefetch addr%0d", tag, i / 8), addr_a, raexp[i / 8 + 1]);
      end
      send_bit(1'b0);
    end
    if (!burst) begin
      check({tag, " miso after"}, miso_a, 0);
      send_bit(1'b0);
    end
    ss_high();
    check({tag, " no err"}, err_a, 0);
    check({tag, " busy end"}, busy_a, 0);
    check({tag, " rd count"}, rd_cnt_a - r0, rds);
  endtask

  initial begin
    int w0;
    rst = 1'b1;
    ss_n_a = 1'b1; mosi_a = 1'b0;
    ss_n_b = 1'b1; mosi_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst miso", miso_a, 0);
    check("rst wr_en", wr_a, 0);
    check("rst rd_en", rd_a, 0);
    check("rst busy", busy_a, 0);
    check("rst err", err_a, 0);
    check("rst addr", addr_a, 0);
    check("rst wdata", wdata_a, 0);
    rst = 1'b0;
    tick();
    check("idle busy", busy_a, 0);

    // Single write 0xA5 @ 0x12
    wdat[0] = 8'hA5; wexp[0] = 8'h12;
    write_frame("swr", 1'b0, 8'h12, 1);

    // Burst write wrapping 0xFE, 0xFF, 0x00
    wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33;
    wexp[0] = 8'hFE; wexp[1] = 8'hFF; wexp[2] = 8'h00;
    write_frame("bwr", 1'b1, 8'hFE, 3);

    // Preload RAM for the reads
    wdat[0] = 8'h3C; wexp[0] = 8'h40;
    write_frame("pre40", 1'b0, 8'h40, 1);
    wdat[0] = 8'h81; wdat[1] = 8'h7E; wdat[2] = 8'hFF;
    wexp[0] = 8'h10; wexp[1] = 8'h11; wexp[2] = 8'h12;
    write_frame("pre10", 1'b1, 8'h10, 3);

    rexp[0] = 8'h3C;
    read_frame("srd", 1'b0, 8'h40, 1, 1);

    rexp[0] = 8'h81; rexp[1] = 8'h7E; rexp[2] = 8'hFF;
    raexp[0] = 8'h10; raexp[1] = 8'h11; raexp[2] = 8'h12;
    read_frame("brd", 1'b1, 8'h10, 3, 4);

    // SS_n rises after 4 data bits of a write
    w0 = wr_cnt_a;
    send_bits(16'h0, 2);
    send_bits(16'h05, 8);
    send_bits(16'hA, 4);
    ss_high();
    check("midword err", err_a, 1);
    check("midword busy", busy_a, 0);
    tick();
    check("midword err pulse", err_a, 0);
    check("midword no wr", wr_cnt_a - w0, 0);

    // SS_n rises during the address phase
    send_bits(16'h0, 2);
    send_bits(16'h5, 3);
    ss_high();
    check("addr abort err", err_a, 1);

    // SS_n rises on the edge sampling the last data bit: write still issued
    send_bits(16'h0, 2);
    send_bits(16'h07, 8);
    send_bits(16'h4B, 7);
    drive(1'b1, 1'b0);
    tick();
    check("lastbit wr_en", wr_a, 1);
    check("lastbit addr", addr_a, 8'h07);
    check("lastbit wdata", wdata_a, 8'h96);
    check("lastbit busy", busy_a, 0);
    check("lastbit err", err_a, 0);

    // Reset during RD_DATA bit 3 of a burst read
    send_bits(16'h3, 2);
    send_bits(16'h10, 8);
    send_bits(16'h0, 2);
    send_bits(16'h0, 3);
    check("pre-rst busy", busy_a, 1);
    rst = 1'b1;
    #1;
    check("mid rst miso", miso_a, 0);
    check("mid rst busy", busy_a, 0);
    check("mid rst rd_en", rd_a, 0);
    check("mid rst wr_en", wr_a, 0);
    check("mid rst err", err_a, 0);
    check("mid rst addr", addr_a, 0);
    ss_n_a = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    wdat[0] = 8'h5A; wexp[0] = 8'h33;
    write_frame("post rst", 1'b0, 8'h33, 1);

    // Instance B (MEM_DEPTH=200): out-of-range address and wrap at 199
    sel_b = 1'b1;
    w0 = wr_cnt_b;
    send_bits(16'h0, 2);
    send_bits(16'hC8, 8);
    check("range err", err_b, 1);
    check("range busy", busy_b, 1);
    check("range no rd", rd_b, 0);
    send_bits(16'hAA, 8);
    check("range err pulse", err_b, 0);
    ss_high();
    check("range no wr", wr_cnt_b - w0, 0);
    check("range no rd cnt", rd_cnt_b, 0);
    check("range busy end", busy_b, 0);

    send_bits(16'h2, 2);
    send_bits(16'hC7, 8);
    send_bits(16'h12, 8);
    check("wrap199 wr_en", wr_b, 1);
    check("wrap199 addr", addr_b, 8'hC7);
    check("wrap199 wdata", wdata_b, 8'h12);
    send_bits(16'h34, 8);
    check("wrap0 addr", addr_b, 8'h00);
    check("wrap0 wdata", wdata_b, 8'h34);
    check("wrap miso", miso_b, 0);
    ss_high();
    check("wrap wr count", wr_cnt_b - w0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
